// File: rtl/mc_fifo_pkg.sv
`default_nettype none
// ============================================================================
// mc_fifo_pkg : width helpers and per-channel status type for mc_fifo
// Revision    : 1.0
// ============================================================================
package mc_fifo_pkg;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ptr_width(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    function automatic int cnt_width(input int d);
        return $clog2(d + 1);
    endfunction

    typedef struct packed {
        logic full;
        logic a_full;
        logic empty;
        logic a_empty;
        logic overflow;
        logic underflow;
    } ch_status_t;

endpackage
`default_nettype wire

// File: rtl/mc_fifo_ch_ctrl.sv
`default_nettype none
// ============================================================================
// mc_fifo_ch_ctrl : pointers, occupancy, status and sticky errors of one channel
// Revision        : 1.0
// ============================================================================
module mc_fifo_ch_ctrl
    import mc_fifo_pkg::*;
#(
    parameter int   DEPTH       = 8,
    parameter int   A_FULL_THR  = 6,
    parameter int   A_EMPTY_THR = 2,
    localparam int  PTR_W       = ptr_width(DEPTH),
    localparam int  CNT_W       = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_wr_req,
    input  logic             i_rd_req,
    input  logic             i_flush,
    input  logic             i_err_clr,
    output logic             o_wr_acc,
    output logic [PTR_W-1:0] o_wptr,
    output logic [PTR_W-1:0] o_rptr,
    output logic [CNT_W-1:0] o_count,
    output ch_status_t       o_status
);

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full   = (r_cnt == CNT_W'(DEPTH));
    assign w_empty  = (r_cnt == '0);
    // A full channel rejects writes even when a same-cycle read frees a slot
    assign w_wr_acc = i_wr_req && !w_full  && !i_flush;
    assign w_rd_acc = i_rd_req && !w_empty && !i_flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= next_ptr(r_wptr);
            if (w_rd_acc) r_rptr <= next_ptr(r_rptr);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // A new error in the same cycle as err_clr takes precedence over the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (i_wr_req && w_full && !i_flush) r_ovf <= 1'b1;
            else if (i_err_clr)                 r_ovf <= 1'b0;
            if (i_rd_req && w_empty && !i_flush) r_unf <= 1'b1;
            else if (i_err_clr)                  r_unf <= 1'b0;
        end
    end

    assign o_wr_acc           = w_wr_acc;
    assign o_wptr             = r_wptr;
    assign o_rptr             = r_rptr;
    assign o_count            = r_cnt;
    assign o_status.full      = w_full;
    assign o_status.a_full    = (int'(r_cnt) >= A_FULL_THR);
    assign o_status.empty     = w_empty;
    assign o_status.a_empty   = (int'(r_cnt) <= A_EMPTY_THR);
    assign o_status.overflow  = r_ovf;
    assign o_status.underflow = r_unf;

endmodule
`default_nettype wire

// File: rtl/mc_fifo.sv
`default_nettype none
// ============================================================================
// mc_fifo : NUM_CH independent FIFOs sharing one storage array, show-ahead read
// Revision : 1.0
// ============================================================================
module mc_fifo
    import mc_fifo_pkg::*;
#(
    parameter int   DATA_W      = 8,
    parameter int   DEPTH       = 8,
    parameter int   NUM_CH      = 4,
    parameter int   A_FULL_THR  = 6,
    parameter int   A_EMPTY_THR = 2,
    localparam int  CH_W        = ch_width(NUM_CH),
    localparam int  PTR_W       = ptr_width(DEPTH),
    localparam int  CNT_W       = cnt_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    write_en,
    input  logic [CH_W-1:0]         write_ch,
    input  logic [DATA_W-1:0]       write_data,
    output logic                    write_ack,
    input  logic                    read_en,
    input  logic [CH_W-1:0]         read_ch,
    output logic [DATA_W-1:0]       read_data,
    output logic                    read_valid,
    input  logic                    flush,
    input  logic [CH_W-1:0]         flush_ch,
    input  logic                    err_clr,
    output logic [NUM_CH-1:0]       full,
    output logic [NUM_CH-1:0]       A_full,
    output logic [NUM_CH-1:0]       empty,
    output logic [NUM_CH-1:0]       A_empty,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       overflow,
    output logic [NUM_CH-1:0]       underflow
);

    logic [DATA_W-1:0] r_mem  [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  w_wptr [NUM_CH];
    logic [PTR_W-1:0]  w_rptr [NUM_CH];
    logic [NUM_CH-1:0] w_wr_req;
    logic [NUM_CH-1:0] w_rd_req;
    logic [NUM_CH-1:0] w_flush;
    logic [NUM_CH-1:0] w_wr_acc;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_valid;

    // Channel decode by equality leaves out-of-range indices matching nothing
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_status_t w_st;

        assign w_wr_req[c] = write_en && (write_ch == CH_W'(c));
        assign w_rd_req[c] = read_en  && (read_ch  == CH_W'(c));
        assign w_flush[c]  = flush    && (flush_ch == CH_W'(c));

        mc_fifo_ch_ctrl #(
            .DEPTH       (DEPTH),
            .A_FULL_THR  (A_FULL_THR),
            .A_EMPTY_THR (A_EMPTY_THR)
        ) u_ctrl (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_wr_req  (w_wr_req[c]),
            .i_rd_req  (w_rd_req[c]),
            .i_flush   (w_flush[c]),
            .i_err_clr (err_clr),
            .o_wr_acc  (w_wr_acc[c]),
            .o_wptr    (w_wptr[c]),
            .o_rptr    (w_rptr[c]),
            .o_count   (count[c*CNT_W +: CNT_W]),
            .o_status  (w_st)
        );

        assign full[c]      = w_st.full;
        assign A_full[c]    = w_st.a_full;
        assign empty[c]     = w_st.empty;
        assign A_empty[c]   = w_st.a_empty;
        assign overflow[c]  = w_st.overflow;
        assign underflow[c] = w_st.underflow;
    end

    assign write_ack = |w_wr_acc;

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_wr_acc[c]) r_mem[c][w_wptr[c]] <= write_data;
        end
    end

    always_comb begin
        w_rd_data  = '0;
        w_rd_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((read_ch == CH_W'(c)) && !empty[c]) begin
                w_rd_valid = 1'b1;
                w_rd_data  = r_mem[c][w_rptr[c]];
            end
        end
    end

    assign read_data  = w_rd_data;
    assign read_valid = w_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_mc_fifo.sv
`default_nettype none
// ============================================================================
// tb_mc_fifo : directed plan steps plus random traffic against a queue model
// Revision   : 1.0
// ============================================================================
module tb_mc_fifo;

    localparam int NCH = 4;
    localparam int DEP = 8;
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           write_en;
    logic [1:0]     write_ch;
    logic [7:0]     write_data;
    logic           write_ack;
    logic           read_en;
    logic [1:0]     read_ch;
    logic [7:0]     read_data;
    logic           read_valid;
    logic           flush;
    logic [1:0]     flush_ch;
    logic           err_clr;
    logic [3:0]     full, A_full, empty, A_empty, overflow, underflow;
    logic [15:0]    count;

    int total = 0;
    int bad   = 0;

    logic [7:0] q [NCH][$];
    bit         m_ovf [NCH];
    bit         m_unf [NCH];

    always #5 clk = ~clk;

    mc_fifo dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .write_en   (write_en),
        .write_ch   (write_ch),
        .write_data (write_data),
        .write_ack  (write_ack),
        .read_en    (read_en),
        .read_ch    (read_ch),
        .read_data  (read_data),
        .read_valid (read_valid),
        .flush      (flush),
        .flush_ch   (flush_ch),
        .err_clr    (err_clr),
        .full       (full),
        .A_full     (A_full),
        .empty      (empty),
        .A_empty    (A_empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("count%0d", c),     32'(count[c*CW +: CW]), q[c].size());
            chk($sformatf("empty%0d", c),     32'(empty[c]),     32'(q[c].size() == 0));
            chk($sformatf("full%0d", c),      32'(full[c]),      32'(q[c].size() == DEP));
            chk($sformatf("A_full%0d", c),    32'(A_full[c]),    32'(q[c].size() >= 6));
            chk($sformatf("A_empty%0d", c),   32'(A_empty[c]),   32'(q[c].size() <= 2));
            chk($sformatf("overflow%0d", c),  32'(overflow[c]),  32'(m_ovf[c]));
            chk($sformatf("underflow%0d", c), 32'(underflow[c]), 32'(m_unf[c]));
        end
        chk("read_valid", 32'(read_valid), 32'(q[read_ch].size() != 0));
        chk("read_data",  32'(read_data),  (q[read_ch].size() != 0) ? 32'(q[read_ch][0]) : 32'd0);
    endtask

    // Called just after a falling edge; returns just after the next falling edge
    task automatic step(input bit we, input int wc, input int wd, input bit re, input int rc,
                        input bit fl, input int fc, input bit ec);
        bit flc [NCH];
        bit exp_ack;
        bit racc;
        write_en   = we;
        write_ch   = wc[1:0];
        write_data = wd[7:0];
        read_en    = re;
        read_ch    = rc[1:0];
        flush      = fl;
        flush_ch   = fc[1:0];
        err_clr    = ec;
        #1;
        for (int c = 0; c < NCH; c++) flc[c] = fl && (fc == c);
        exp_ack = we && (q[wc].size() < DEP) && !flc[wc];
        racc    = re && (q[rc].size() > 0) && !flc[rc];
        chk("write_ack", 32'(write_ack), 32'(exp_ack));
        for (int c = 0; c < NCH; c++) begin
            if (we && wc == c && q[c].size() == DEP && !flc[c]) m_ovf[c] = 1'b1;
            else if (ec)                                         m_ovf[c] = 1'b0;
            if (re && rc == c && q[c].size() == 0 && !flc[c])   m_unf[c] = 1'b1;
            else if (ec)                                         m_unf[c] = 1'b0;
        end
        if (racc)    void'(q[rc].pop_front());
        if (exp_ack) q[wc].push_back(wd[7:0]);
        if (fl)      q[fc].delete();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input int d);
        step(1'b1, ch, d, 1'b0, ch, 1'b0, 0, 1'b0);
    endtask

    task automatic rd(input int ch);
        step(1'b0, 0, 0, 1'b1, ch, 1'b0, 0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        write_en = 1'b0; write_ch = '0; write_data = '0;
        read_en = 1'b0;  read_ch = '0;  flush = 1'b0; flush_ch = '0; err_clr = 1'b0;
        for (int c = 0; c < NCH; c++) begin m_ovf[c] = 1'b0; m_unf[c] = 1'b0; end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_all();

        // Fill ch2 past full
        for (int i = 0; i < 9; i++) wr(2, 8'hA0 + i);
        chk("plan_ovf2",  32'(overflow[2]), 32'd1);
        chk("plan_full2", 32'(full[2]),     32'd1);

        // Drain and wrap on ch1
        for (int i = 0; i < 8; i++) wr(1, 8'h10 + i);
        for (int i = 0; i < 3; i++) rd(1);
        for (int i = 0; i < 3; i++) wr(1, 8'h20 + i);
        step(1'b0, 0, 0, 1'b0, 1, 1'b0, 0, 1'b0);
        chk("plan_head1", 32'(read_data), 32'h13);
        for (int i = 0; i < 8; i++) rd(1);
        rd(1);
        chk("plan_unf1", 32'(underflow[1]), 32'd1);

        // Simultaneous ops: non-empty, full, empty channels
        for (int i = 0; i < 4; i++) wr(0, 8'h30 + i);
        step(1'b1, 0, 8'h34, 1'b1, 0, 1'b0, 0, 1'b0);
        chk("plan_cnt0", 32'(count[3:0]), 32'd4);
        for (int i = 0; i < 8; i++) wr(3, 8'h40 + i);
        step(1'b1, 3, 8'h48, 1'b1, 3, 1'b0, 0, 1'b0);
        chk("plan_cnt3", 32'(count[15:12]), 32'd7);
        step(1'b0, 0, 0, 1'b0, 0, 1'b1, 2, 1'b0);
        step(1'b1, 2, 8'h50, 1'b1, 2, 1'b0, 0, 1'b0);
        chk("plan_cnt2", 32'(count[11:8]), 32'd1);

        // Flush collision on ch1
        for (int i = 0; i < 5; i++) wr(1, 8'h60 + i);
        step(1'b1, 1, 8'h77, 1'b1, 1, 1'b1, 1, 1'b0);
        chk("plan_cnt1", 32'(count[7:4]), 32'd0);

        // Error clear racing a new overflow
        for (int i = 0; i < 4; i++) wr(0, 8'h70 + i);
        wr(0, 8'hFF);
        step(1'b1, 0, 8'hFE, 1'b0, 0, 1'b0, 0, 1'b1);
        chk("plan_ovf0_keep", 32'(overflow[0]), 32'd1);
        step(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
        chk("plan_ovf0_clr", 32'(overflow[0]), 32'd0);

        // Asynchronous reset while ch2 holds 5 words
        for (int i = 0; i < 4; i++) wr(2, 8'h80 + i);
        write_en = 1'b0; read_en = 1'b0; flush = 1'b0; err_clr = 1'b0; read_ch = 2'd2;
        #2;
        reset_n = 1'b0;
        #1;
        for (int c = 0; c < NCH; c++) begin q[c].delete(); m_ovf[c] = 1'b0; m_unf[c] = 1'b0; end
        check_all();
        chk("async_empty", 32'(empty), 32'hF);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 2, 8'hA5, 1'b0, 2, 1'b0, 0, 1'b0);
        chk("post_reset_data", 32'(read_data), 32'hA5);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 15) == 0), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
